// File: rtl/sar_adc_pkg.sv
// Shared types for the SAR ADC scan controller.
//   state_t  : scan FSM encoding
//   ch_width : width of a channel index for a given channel count (min 1 bit)
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_ch_picker.sv
// Combinational channel picker for the scan sequencer.
//   mask      in   NUM_CH  latched scan mask
//   cur       in   CH_W    channel currently being converted
//   wrap_mask in   NUM_CH  live enable mask, used for scan start / wrap
//   found     out  1       an enabled channel above cur exists in mask
//   next_ch   out  CH_W    lowest enabled channel above cur
//   first_ch  out  CH_W    lowest set bit of wrap_mask
module sar_ch_picker #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic [NUM_CH-1:0] wrap_mask,
  output logic              found,
  output logic [CH_W-1:0]   next_ch,
  output logic [CH_W-1:0]   first_ch
);

  // Scanning from the top down leaves the lowest qualifying index last.
  always_comb begin
    found    = 1'b0;
    next_ch  = '0;
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        found   = 1'b1;
        next_ch = i[CH_W-1:0];
      end
      if (wrap_mask[i]) begin
        first_ch = i[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: samples each enabled mux channel,
// runs a binary search against the cap-DAC, averages 2^AVG_LOG2 conversions
// and streams the result out on a valid/ready interface tagged with channel.
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i, cont_i        start a scan / rescan continuously
//   ch_en_i                channel enable mask
//   comp_p_i, comp_n_i     differential comparator outputs
//   sample_o, ch_sel_o     sampling phase, analog mux select
//   dac_p_o, dac_n_o       positive / negative DAC codes
//   valid_o, ready_i       result handshake
//   data_o, ch_o           averaged result and its channel
//   busy_o, done_o         scan in progress / end-of-scan pulse
//
// state   | meaning
// IDLE    | waiting for start_i with a non-empty mask
// SAMPLE  | sample_o high for SAMPLE_CYCLES, DAC cleared
// CONVERT | one bit per SETTLE_CYCLES+1 cycles, MSB first
// OUTPUT  | result presented, held until ready_i
module sar_adc_scan_ctrl
  import sar_adc_pkg::*;
#(
  parameter int RESOLUTION    = 8,
  parameter int NUM_CH        = 4,
  parameter int AVG_LOG2      = 2,
  parameter int SAMPLE_CYCLES = 1,
  parameter int SETTLE_CYCLES = 0,
  localparam int CH_W = ch_width(NUM_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  cont_i,
  input  logic [NUM_CH-1:0]     ch_en_i,
  input  logic                  comp_p_i,
  input  logic                  comp_n_i,
  output logic                  sample_o,
  output logic [CH_W-1:0]       ch_sel_o,
  output logic [RESOLUTION-1:0] dac_p_o,
  output logic [RESOLUTION-1:0] dac_n_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [RESOLUTION-1:0] data_o,
  output logic [CH_W-1:0]       ch_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int ACC_W = RESOLUTION + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(2 ** AVG_LOG2 - 1);
  localparam logic [SMP_W-1:0] SMP_LOAD  = SMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETTLE_CYCLES);
  localparam logic [RESOLUTION-1:0] MSB  = {1'b1, {(RESOLUTION-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [SMP_W-1:0]        smp_cnt_q, smp_cnt_d;
  logic [SET_W-1:0]        set_cnt_q, set_cnt_d;
  logic [RESOLUTION-1:0]   bit_q, bit_d;
  logic [RESOLUTION-1:0]   result_q, result_d, res_fin;
  logic [RESOLUTION-1:0]   dac_p_q, dac_p_d, dac_n_q, dac_n_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        conv_cnt_q, conv_cnt_d;
  logic                    done_q, done_d;

  logic                    comp;
  logic                    found;
  logic [CH_W-1:0]         next_ch, first_ch;

  // Both-high and both-low are treated as "DAC above input".
  assign comp = comp_p_i & ~comp_n_i;

  sar_ch_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_picker (
    .mask      (mask_q),
    .cur       (ch_q),
    .wrap_mask (ch_en_i),
    .found     (found),
    .next_ch   (next_ch),
    .first_ch  (first_ch)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      mask_q     <= '0;
      smp_cnt_q  <= '0;
      set_cnt_q  <= '0;
      bit_q      <= '0;
      result_q   <= '0;
      dac_p_q    <= '0;
      dac_n_q    <= '0;
      acc_q      <= '0;
      conv_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      smp_cnt_q  <= smp_cnt_d;
      set_cnt_q  <= set_cnt_d;
      bit_q      <= bit_d;
      result_q   <= result_d;
      dac_p_q    <= dac_p_d;
      dac_n_q    <= dac_n_d;
      acc_q      <= acc_d;
      conv_cnt_q <= conv_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    smp_cnt_d  = smp_cnt_q;
    set_cnt_d  = set_cnt_q;
    bit_d      = bit_q;
    result_d   = result_q;
    dac_p_d    = dac_p_q;
    dac_n_d    = dac_n_q;
    acc_d      = acc_q;
    conv_cnt_d = conv_cnt_q;
    done_d     = 1'b0;
    res_fin    = comp ? (result_q | bit_q) : result_q;

    case (state_q)
      IDLE: begin
        if (start_i && (ch_en_i != '0)) begin
          mask_d    = ch_en_i;
          ch_d      = first_ch;
          smp_cnt_d = SMP_LOAD;
          state_d   = SAMPLE;
        end
      end

      SAMPLE: begin
        if (smp_cnt_q == '0) begin
          bit_d     = MSB;
          set_cnt_d = SET_LOAD;
          state_d   = CONVERT;
        end else begin
          smp_cnt_d = smp_cnt_q - 1'b1;
        end
      end

      CONVERT: begin
        if (set_cnt_q != '0) begin
          set_cnt_d = set_cnt_q - 1'b1;
        end else begin
          set_cnt_d = SET_LOAD;
          bit_d     = bit_q >> 1;
          result_d  = res_fin;
          if (comp) dac_p_d = dac_p_q ^ bit_q;
          else      dac_n_d = dac_n_q ^ bit_q;
          if (bit_q[0]) begin
            // Last bit: accumulate and leave the DAC cleared for the next phase.
            acc_d    = acc_q + ACC_W'(res_fin);
            result_d = '0;
            dac_p_d  = '0;
            dac_n_d  = '0;
            if (conv_cnt_q == CONV_LAST) begin
              conv_cnt_d = '0;
              state_d    = OUTPUT;
            end else begin
              conv_cnt_d = conv_cnt_q + 1'b1;
              smp_cnt_d  = SMP_LOAD;
              state_d    = SAMPLE;
            end
          end
        end
      end

      OUTPUT: begin
        if (ready_i) begin
          acc_d = '0;
          if (found) begin
            ch_d      = next_ch;
            smp_cnt_d = SMP_LOAD;
            state_d   = SAMPLE;
          end else if (cont_i && (ch_en_i != '0)) begin
            mask_d    = ch_en_i;
            ch_d      = first_ch;
            smp_cnt_d = SMP_LOAD;
            state_d   = SAMPLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sample_o = (state_q == SAMPLE);
  assign valid_o  = (state_q == OUTPUT);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign ch_sel_o = busy_o ? ch_q : '0;
  assign ch_o     = valid_o ? ch_q : '0;
  assign data_o   = valid_o ? acc_q[ACC_W-1:AVG_LOG2] : '0;
  assign dac_p_o  = dac_p_q;
  assign dac_n_o  = dac_n_q;

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Self-checking bench for sar_adc_scan_ctrl: a default 4-channel averaging
// instance plus a single-channel, no-averaging instance for latency checks.
// A behavioural comparator converts per-channel codes; expected averages are
// queued at scan start and popped on each accepted result.
module tb_sar_adc_scan_ctrl;

  typedef struct packed {
    logic [3:0]      ch_en;
    logic [3:0][7:0] base;
    logic [7:0]      delta;
  } vec_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  vec_t vecs[5];

  logic rst, start, cont, ready, force_both;
  logic [3:0] ch_en;
  logic comp_p, comp_n;
  logic sample, valid, busy, done;
  logic [1:0] ch_sel, ch;
  logic [7:0] dac_p, dac_n, data;

  logic start1, ready1;
  logic comp_p1, comp_n1;
  logic sample1, valid1, busy1, done1;
  logic ch_sel1, ch1;
  logic [7:0] dac_p1, dac_n1, data1;

  logic [3:0][7:0] cur_base;
  logic [7:0] cur_delta;
  logic [7:0] tb_mask, tb_mask1, code_now, trial, trial1;
  logic [1:0] k;
  logic in_conv, in_conv1;

  sar_adc_scan_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .ch_en_i(ch_en),
    .comp_p_i(comp_p), .comp_n_i(comp_n), .sample_o(sample), .ch_sel_o(ch_sel),
    .dac_p_o(dac_p), .dac_n_o(dac_n), .valid_o(valid), .ready_i(ready),
    .data_o(data), .ch_o(ch), .busy_o(busy), .done_o(done)
  );

  sar_adc_scan_ctrl #(.NUM_CH(1), .AVG_LOG2(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .cont_i(1'b0), .ch_en_i(1'b1),
    .comp_p_i(comp_p1), .comp_n_i(comp_n1), .sample_o(sample1), .ch_sel_o(ch_sel1),
    .dac_p_o(dac_p1), .dac_n_o(dac_n1), .valid_o(valid1), .ready_i(ready1),
    .data_o(data1), .ch_o(ch1), .busy_o(busy1), .done_o(done1)
  );

  // Comparator model: input code vs. trial level (bits decided so far | current bit).
  assign in_conv  = busy && !sample && !valid;
  assign in_conv1 = busy1 && !sample1 && !valid1;

  always @(posedge clk) begin
    if (rst) begin
      tb_mask  <= 8'h00;
      tb_mask1 <= 8'h00;
      k        <= 2'd0;
    end else begin
      if (sample) tb_mask <= 8'h80;
      else if (in_conv) tb_mask <= tb_mask >> 1;
      if (sample1) tb_mask1 <= 8'h80;
      else if (in_conv1) tb_mask1 <= tb_mask1 >> 1;
      if (start && !busy) k <= 2'd0;
      else if (in_conv && tb_mask == 8'h01) k <= k + 2'd1;
    end
  end

  always_comb begin
    code_now = cur_base[ch_sel] + {6'b0, k} * cur_delta;
    trial    = dac_p | tb_mask;
    trial1   = dac_p1 | tb_mask1;
    comp_p   = force_both ? 1'b1 : (code_now >= trial);
    comp_n   = force_both ? 1'b1 : !(code_now >= trial);
    comp_p1  = (8'hA5 >= trial1);
    comp_n1  = !(8'hA5 >= trial1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic [7:0] b3, input logic [7:0] b2,
                              input logic [7:0] b1, input logic [7:0] b0, input logic [7:0] d);
    vec_t v;
    v.ch_en = en;
    v.base  = {b3, b2, b1, b0};
    v.delta = d;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    int s;
    for (int c = 0; c < 4; c++) begin
      if (v.ch_en[c]) begin
        s = 0;
        for (int kk = 0; kk < 4; kk++) s += int'(v.base[c]) + kk * int'(v.delta);
        e.ch   = 2'(c);
        e.data = 8'(s / 4);
        exp_q.push_back(e);
      end
    end
  endtask

  // Call at a falling edge; start is released by whatever waits next.
  task automatic start_scan(input vec_t v, input logic c, input bit push);
    cur_base  = v.base;
    cur_delta = v.delta;
    ch_en     = v.ch_en;
    cont      = c;
    if (push) push_exp(v);
    start = 1'b1;
  endtask

  task automatic drain(input int drop_at, input int poke_at);
    int cyc;
    int pops;
    bit seen_done;
    exp_t e;
    cyc = 0;
    pops = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("extra_result", 32'(ch), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("result_data", 32'(data), 32'(e.data));
          check("result_ch", 32'(ch), 32'(e.ch));
          pops++;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check("queue_empty_at_done", 32'(exp_q.size()), 0);
      end
      if (force_both && in_conv && tb_mask == 8'h01) begin
        // LSB decision is comp=0 too, completing dac_n as all ones.
        check("both_high_dac_n", 32'(dac_n), 32'hFE);
        check("both_high_dac_p", 32'(dac_p), 0);
      end
      if (drop_at >= 0 && pops >= drop_at && ch_sel == 2'd2) cont = 1'b0;
      start = (cyc == poke_at);
    end
    check("done_seen", 32'(seen_done), 1);
    check("idle_after_scan", 32'(busy), 0);
  endtask

  initial begin
    int cyc;
    int first_valid;
    int scount;
    exp_t e;

    vecs[0] = mk(4'b0001, 8'h00, 8'h00, 8'h00, 8'd10, 8'd1);
    vecs[1] = mk(4'b1010, 8'hC3, 8'h00, 8'h40, 8'h00, 8'd0);
    vecs[2] = mk(4'b1111, 8'h80, 8'h55, 8'hFF, 8'h00, 8'd0);
    vecs[3] = mk(4'b0100, 8'h00, 8'h7F, 8'h00, 8'h00, 8'd2);
    vecs[4] = mk(4'b1001, 8'hF0, 8'h00, 8'h00, 8'h01, 8'd3);

    rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b1; force_both = 1'b0;
    ch_en = 4'b0; cur_base = '0; cur_delta = '0;
    start1 = 1'b0; ready1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({sample, ch_sel, valid, busy, done, ch}), 0);
    check("rst_dac", 32'({dac_p, dac_n}), 0);
    check("rst_data", 32'(data), 0);
    check("rst_dut1", 32'({sample1, ch_sel1, valid1, busy1, done1, ch1, dac_p1, dac_n1, data1}), 0);
    rst = 1'b0;

    // Single conversion latency on the 1-channel, no-averaging instance.
    @(negedge clk);
    start1 = 1'b1;
    first_valid = -1;
    scount = 0;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (sample1) scount++;
      if (valid1 && first_valid < 0) first_valid = t;
    end
    check("t1_sample_cycles", 32'(scount), 1);
    check("t1_valid_latency", 32'(first_valid), 10);
    check("t1_data", 32'(data1), 32'hA5);
    check("t1_ch", 32'(ch1), 0);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    check("t1_done", 32'(done1), 1);
    check("t1_idle", 32'(busy1), 0);

    // Table of scans on the averaging instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_scan(vecs[i], 1'b0, 1'b1);
      drain(-1, 0);
    end

    // Empty mask: start has no effect.
    @(negedge clk);
    ch_en = 4'b0000;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("empty_mask_busy", 32'(busy), 0);
      check("empty_mask_done", 32'(done), 0);
    end

    // Back-pressure at OUTPUT.
    @(negedge clk);
    ready = 1'b0;
    start_scan(mk(4'b0011, 8'h00, 8'h00, 8'h66, 8'h33, 8'd0), 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_valid_seen", 32'(valid), 1);
    e = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", 32'(valid), 1);
      check("stall_data", 32'(data), 32'(e.data));
      check("stall_ch", 32'(ch), 32'(e.ch));
      check("stall_no_sample", 32'(sample), 0);
      if (i < 5) @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    check("post_accept_sample", 32'(sample), 1);
    check("post_accept_ch_sel", 32'(ch_sel), 1);
    check("post_accept_valid", 32'(valid), 0);
    drain(-1, 0);

    // Continuous scan: one wrap, cont dropped during channel 2 of the second pass.
    @(negedge clk);
    start_scan(mk(4'b1111, 8'h78, 8'h56, 8'h34, 8'h12, 8'd1), 1'b1, 1'b1);
    push_exp(mk(4'b1111, 8'h78, 8'h56, 8'h34, 8'h12, 8'd1));
    drain(4, 0);
    check("cont_dropped", 32'(cont), 0);

    // start_i pulsed mid-scan with a wider live mask must change nothing.
    @(negedge clk);
    start_scan(mk(4'b0011, 8'h00, 8'h00, 8'h87, 8'h21, 8'd0), 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    ch_en = 4'b1111;
    drain(-1, 5);

    // Comparator both-high: every decision is 0.
    @(negedge clk);
    force_both = 1'b1;
    start_scan(mk(4'b0001, 8'h00, 8'h00, 8'h00, 8'hC8, 8'd0), 1'b0, 1'b0);
    e.ch = 2'd0;
    e.data = 8'h00;
    exp_q.push_back(e);
    drain(-1, 0);
    force_both = 1'b0;

    // Reset mid-CONVERT.
    @(negedge clk);
    start_scan(mk(4'b0001, 8'h00, 8'h00, 8'h00, 8'h5A, 8'd0), 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!in_conv && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_convert", 32'(in_conv), 1);
    repeat (3) @(negedge clk);
    check("pre_rst_dac_active", 32'((dac_p | dac_n) != 8'h00), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", 32'({sample, ch_sel, valid, busy, done, ch}), 0);
    check("midrst_dac", 32'({dac_p, dac_n}), 0);
    check("midrst_data", 32'(data), 0);
    rst = 1'b0;

    @(negedge clk);
    start_scan(vecs[3], 1'b0, 1'b1);
    drain(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
